// File: rtl/axi4_lite_pkg.sv
// ============================================================================
// Module : axi4_lite_pkg
// Brief  : Shared AXI4-Lite types (response codes, master FSM states, widths)
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi4_lite_pkg;

    localparam int AXI4_LITE_ADDR_W = 4;
    localparam int AXI4_LITE_DATA_W = 32;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WR_ADDR_DATA = 3'd1,
        ST_WR_RESP      = 3'd2,
        ST_RD_ADDR      = 3'd3,
        ST_RD_DATA      = 3'd4
    } master_state_e;

endpackage

`default_nettype wire

// File: rtl/axi4_lite_master.sv
// ============================================================================
// Module : axi4_lite_master
// Brief  : Single-outstanding AXI4-Lite initiator; optional abort timer
//          enabled by defining AXI4_LITE_MASTER_TIMEOUT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4_lite_master
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_W         = AXI4_LITE_ADDR_W,
    parameter int DATA_W         = AXI4_LITE_DATA_W,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              ACLK,
    input  logic              ARESET,
    // user command side
    input  logic              transfer,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        resp,
    output logic              timeout,
    // AXI4-Lite
    output logic [ADDR_W-1:0] AWADDR,
    output logic              AWVALID,
    input  logic              AWREADY,
    output logic [DATA_W-1:0] WDATA,
    output logic              WVALID,
    input  logic              WREADY,
    input  logic [1:0]        BRESP,
    input  logic              BVALID,
    output logic              BREADY,
    output logic [ADDR_W-1:0] ARADDR,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [DATA_W-1:0] RDATA,
    input  logic              RVALID,
    input  logic [1:0]        RRESP,
    output logic              RREADY
);

    master_state_e     state_q, state_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        resp_q, resp_d;
    logic              done_q, done_d;

    logic w_accept, w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic w_wr_addr_data_done, w_complete, w_expired, w_abort;

    assign w_accept = (state_q == ST_IDLE) && transfer;
    assign w_aw_hs  = awvalid_q && AWREADY;
    assign w_w_hs   = wvalid_q && WREADY;
    assign w_b_hs   = bready_q && BVALID;
    assign w_ar_hs  = arvalid_q && ARREADY;
    assign w_r_hs   = rready_q && RVALID;

    // Each channel is finished once its VALID is already low or handshakes now.
    assign w_wr_addr_data_done = (!awvalid_q || w_aw_hs) && (!wvalid_q || w_w_hs);

    assign w_complete = ((state_q == ST_WR_RESP) && w_b_hs) ||
                        ((state_q == ST_RD_DATA) && w_r_hs);
    assign w_abort    = w_expired && !w_complete;

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    localparam int              CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    // Abort edge chosen so done lands TIMEOUT_CYCLES cycles after the command.
    localparam logic [CNT_W-1:0] EXPIRE_AT = CNT_W'(TIMEOUT_CYCLES - 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q;

    always_comb begin
        cnt_d = cnt_q;
        if (w_accept) begin
            cnt_d = '0;
        end else if ((state_q != ST_IDLE) && (cnt_q < EXPIRE_AT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= w_abort;
        end
    end

    assign w_expired = (state_q != ST_IDLE) && (cnt_q >= EXPIRE_AT);
    assign timeout   = timeout_q;
`else
    assign w_expired = 1'b0;
    // Constant 0: the timer is compiled out in this build.
    assign timeout   = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (transfer) state_d = write ? ST_WR_ADDR_DATA : ST_RD_ADDR;
            end
            ST_WR_ADDR_DATA: if (w_wr_addr_data_done) state_d = ST_WR_RESP;
            ST_WR_RESP:      if (w_b_hs)              state_d = ST_IDLE;
            ST_RD_ADDR:      if (w_ar_hs)             state_d = ST_RD_DATA;
            ST_RD_DATA:      if (w_r_hs)              state_d = ST_IDLE;
            default:                                  state_d = ST_IDLE;
        endcase
        if (w_abort) state_d = ST_IDLE;
    end

    always_comb begin
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awaddr_d  = awaddr_q;
        araddr_d  = araddr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        done_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (transfer && write) begin
                    awaddr_d  = addr;
                    wdata_d   = wdata;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end else if (transfer) begin
                    araddr_d  = addr;
                    arvalid_d = 1'b1;
                end
            end
            ST_WR_ADDR_DATA: begin
                if (w_aw_hs)             awvalid_d = 1'b0;
                if (w_w_hs)              wvalid_d  = 1'b0;
                if (w_wr_addr_data_done) bready_d  = 1'b1;
            end
            ST_WR_RESP: begin
                if (w_b_hs) begin
                    bready_d = 1'b0;
                    resp_d   = BRESP;
                    done_d   = 1'b1;
                end
            end
            ST_RD_ADDR: begin
                if (w_ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            ST_RD_DATA: begin
                if (w_r_hs) begin
                    rready_d = 1'b0;
                    rdata_d  = RDATA;
                    resp_d   = RRESP;
                    done_d   = 1'b1;
                end
            end
            default: ;
        endcase
        if (w_abort) begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            resp_d    = RESP_SLVERR;
            done_d    = 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            done_q    <= done_d;
        end
    end

    assign ready   = (state_q == ST_IDLE);
    assign done    = done_q;
    assign rdata   = rdata_q;
    assign resp    = resp_q;
    assign AWADDR  = awaddr_q;
    assign AWVALID = awvalid_q;
    assign WDATA   = wdata_q;
    assign WVALID  = wvalid_q;
    assign BREADY  = bready_q;
    assign ARADDR  = araddr_q;
    assign ARVALID = arvalid_q;
    assign RREADY  = rready_q;

endmodule

`default_nettype wire

// File: tb/tb_axi4_lite_master.sv
// ============================================================================
// Module : tb_axi4_lite_master
// Brief  : Directed self-checking bench for axi4_lite_master
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi4_lite_master;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        transfer, write;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        ready, done, timeout;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic [3:0]  AWADDR, ARADDR;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] WDATA, RDATA;
    logic [1:0]  BRESP, RRESP;

    int n_checks = 0;
    int n_errors = 0;

    axi4_lite_master #(
        .ADDR_W         (4),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (8)
    ) u_dut (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .transfer (transfer),
        .write    (write),
        .addr     (addr),
        .wdata    (wdata),
        .ready    (ready),
        .done     (done),
        .rdata    (rdata),
        .resp     (resp),
        .timeout  (timeout),
        .AWADDR   (AWADDR),
        .AWVALID  (AWVALID),
        .AWREADY  (AWREADY),
        .WDATA    (WDATA),
        .WVALID   (WVALID),
        .WREADY   (WREADY),
        .BRESP    (BRESP),
        .BVALID   (BVALID),
        .BREADY   (BREADY),
        .ARADDR   (ARADDR),
        .ARVALID  (ARVALID),
        .ARREADY  (ARREADY),
        .RDATA    (RDATA),
        .RVALID   (RVALID),
        .RRESP    (RRESP),
        .RREADY   (RREADY)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic slave_idle();
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
        ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0;    RRESP = 2'b00;
    endtask

    int done_at;
    int done_cnt;
    logic       s_timeout, s_arvalid;
    logic [1:0] s_resp;
    logic [31:0] s_rdata;

    initial begin
        ARESET = 1'b1; transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;
        slave_idle();
        tick(); tick();
        ARESET = 1'b0;

        // reset state
        check("rst_ready",   ready,   1);
        check("rst_done",    done,    0);
        check("rst_awvalid", AWVALID, 0);
        check("rst_arvalid", ARVALID, 0);
        check("rst_bready",  BREADY,  0);
        check("rst_rdata",   rdata,   0);
        check("rst_timeout", timeout, 0);

        // 1: zero-wait write
        AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1; BRESP = 2'b00;
        transfer = 1'b1; write = 1'b1; addr = 4'h4; wdata = 32'hDEADBEEF;
        tick(); transfer = 1'b0;
        check("t1_awvalid", AWVALID, 1);
        check("t1_wvalid",  WVALID,  1);
        check("t1_awaddr",  AWADDR,  4'h4);
        check("t1_wdata",   WDATA,   32'hDEADBEEF);
        check("t1_busy",    ready,   0);
        tick();
        check("t1_aw_drop", AWVALID, 0);
        check("t1_w_drop",  WVALID,  0);
        check("t1_bready",  BREADY,  1);
        check("t1_nodone",  done,    0);
        tick();
        check("t1_done",    done,    1);
        check("t1_resp",    resp,    2'b00);
        check("t1_ready",   ready,   1);
        check("t1_tmo",     timeout, 0);
        check("t1_b_drop",  BREADY,  0);
        tick();
        check("t1_pulse",   done,    0);
        slave_idle();

        // 2: AWREADY late, WREADY immediate, SLVERR passed through
        WREADY = 1'b1; BVALID = 1'b1; BRESP = 2'b10;
        transfer = 1'b1; write = 1'b1; addr = 4'hC; wdata = 32'hA5A5A5A5;
        tick(); transfer = 1'b0;
        check("t2_awvalid_c1", AWVALID, 1);
        check("t2_wvalid_c1",  WVALID,  1);
        tick();
        check("t2_w_drop",     WVALID,  0);
        check("t2_awvalid_c2", AWVALID, 1);
        check("t2_bready_c2",  BREADY,  0);
        tick();
        check("t2_awvalid_c3", AWVALID, 1);
        check("t2_awaddr_c3",  AWADDR,  4'hC);
        check("t2_bready_c3",  BREADY,  0);
        check("t2_nodone_c3",  done,    0);
        AWREADY = 1'b1;
        tick(); AWREADY = 1'b0;
        check("t2_aw_drop",    AWVALID, 0);
        check("t2_bready_c4",  BREADY,  1);
        check("t2_nodone_c4",  done,    0);
        tick();
        check("t2_done",       done,    1);
        check("t2_resp",       resp,    2'b10);
        tick();
        check("t2_pulse",      done,    0);
        slave_idle();

        // 3: read with ARREADY one cycle late, RVALID two cycles late
        transfer = 1'b1; write = 1'b0; addr = 4'h8;
        tick(); transfer = 1'b0;
        check("t3_arvalid_c1", ARVALID, 1);
        check("t3_araddr",     ARADDR,  4'h8);
        check("t3_rready_c1",  RREADY,  0);
        tick();
        check("t3_arvalid_c2", ARVALID, 1);
        ARREADY = 1'b1;
        tick(); ARREADY = 1'b0;
        check("t3_ar_drop",    ARVALID, 0);
        check("t3_rready_c3",  RREADY,  1);
        tick();
        check("t3_rready_c4",  RREADY,  1);
        check("t3_nodone_c4",  done,    0);
        tick();
        RVALID = 1'b1; RDATA = 32'h12345678; RRESP = 2'b00;
        tick(); RVALID = 1'b0; RDATA = '0;
        check("t3_done",       done,    1);
        check("t3_rdata",      rdata,   32'h12345678);
        check("t3_resp",       resp,    2'b00);
        check("t3_r_drop",     RREADY,  0);
        tick();

        // 4: transfer while busy is dropped, transfer in done cycle is taken
        AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1; BRESP = 2'b00;
        ARREADY = 1'b1; RVALID = 1'b1; RDATA = 32'hCAFEF00D; RRESP = 2'b01;
        transfer = 1'b1; write = 1'b1; addr = 4'h0; wdata = 32'h11111111;
        tick();
        write = 1'b0; addr = 4'h4;
        check("t4_busy", ready, 0);
        tick(); transfer = 1'b0;
        check("t4_ignored_ar", ARVALID, 0);
        check("t4_bready",     BREADY,  1);
        tick();
        check("t4_wr_done",    done,    1);
        check("t4_ready",      ready,   1);
        check("t4_rdata_keep", rdata,   32'h12345678);
        transfer = 1'b1; write = 1'b0; addr = 4'h4;
        tick(); transfer = 1'b0;
        check("t4_arvalid",    ARVALID, 1);
        check("t4_araddr",     ARADDR,  4'h4);
        tick();
        check("t4_rready",     RREADY,  1);
        tick();
        check("t4_rd_done",    done,    1);
        check("t4_rdata",      rdata,   32'hCAFEF00D);
        check("t4_resp",       resp,    2'b01);
        tick();
        slave_idle();

        // 6: slave never answers AR
        transfer = 1'b1; write = 1'b0; addr = 4'hC;
        done_at = 0; done_cnt = 0;
        s_timeout = 1'b0; s_arvalid = 1'b1; s_resp = '0; s_rdata = '0;
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
        for (int k = 1; k <= 12; k++) begin
            tick(); transfer = 1'b0;
            if (done) begin
                done_cnt++;
                if (done_at == 0) begin
                    done_at   = k;
                    s_timeout = timeout;
                    s_resp    = resp;
                    s_rdata   = rdata;
                    s_arvalid = ARVALID;
                end
            end
        end
        check("t6_done_cycle", done_at,   8);
        check("t6_done_count", done_cnt,  1);
        check("t6_timeout",    s_timeout, 1);
        check("t6_resp",       s_resp,    2'b10);
        check("t6_rdata_keep", s_rdata,   32'hCAFEF00D);
        check("t6_ar_drop",    s_arvalid, 0);
        check("t6_ready",      ready,     1);
`else
        for (int k = 1; k <= 1000; k++) begin
            tick(); transfer = 1'b0;
            if (done) done_cnt++;
            if (timeout) s_timeout = 1'b1;
        end
        check("t6_no_done",  done_cnt, 0);
        check("t6_no_tmo",   s_timeout, 0);
        check("t6_arvalid",  ARVALID,  1);
        check("t6_araddr",   ARADDR,   4'hC);
        check("t6_busy",     ready,    0);
        ARESET = 1'b1;
        tick(); ARESET = 1'b0;
        check("t6_rst_ar",    ARVALID, 0);
        check("t6_rst_ready", ready,   1);
`endif
        tick();

        // 5: reset in the middle of a write address/data phase
        transfer = 1'b1; write = 1'b1; addr = 4'h4; wdata = 32'hFFFF0000;
        tick(); transfer = 1'b0;
        check("t5_awvalid", AWVALID, 1);
        ARESET = 1'b1;
        tick(); ARESET = 1'b0;
        check("t5_aw_drop", AWVALID, 0);
        check("t5_w_drop",  WVALID,  0);
        check("t5_ready",   ready,   1);
        check("t5_nodone",  done,    0);
        check("t5_awaddr",  AWADDR,  0);
        check("t5_wdata",   WDATA,   0);
        check("t5_rdata",   rdata,   0);
        tick();
        check("t5_nodone2", done,    0);
        check("t5_aw_idle", AWVALID, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
